// File: rtl/bnn_lif_accum_pkg.sv
// rtl/bnn_lif_accum_pkg.sv - shared constants and state encoding for the BNN LIF neuron stage
//
// Purpose : word width of the upstream XNOR array, bipolar contribution offset,
//           and the neuron FSM state encoding.
// Ports   : none (package).
package bnn_lif_accum_pkg;

  localparam int BNN_IN_W       = 32;
  // A word with popcount p contributes 2*p - CONTRIB_OFFSET (range -32..+32).
  localparam int CONTRIB_OFFSET = 32;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_EVAL  = 2'd1,
    ST_OUT   = 2'd2
  } lif_state_e;

endpackage

// File: rtl/bnn_lif_accum_popcount.sv
// rtl/bnn_lif_accum_popcount.sv - 32-bit popcount as an adder tree of 4-bit slices
//
// Purpose : combinational population count, reusable by other neuron variants.
// Ports   : din   in  32  word to count
//           count out 6   number of set bits (0..32)
module popcount_32bits (
  input  logic [31:0] din,
  output logic [5:0]  count
);

  logic [2:0] nib_cnt [8];
  logic [3:0] lvl2    [4];
  logic [4:0] lvl3    [2];

  for (genvar i = 0; i < 8; i++) begin : g_nib
    assign nib_cnt[i] = {2'b00, din[4*i]}   + {2'b00, din[4*i+1]}
                      + {2'b00, din[4*i+2]} + {2'b00, din[4*i+3]};
  end

  for (genvar i = 0; i < 4; i++) begin : g_lvl2
    assign lvl2[i] = {1'b0, nib_cnt[2*i]} + {1'b0, nib_cnt[2*i+1]};
  end

  for (genvar i = 0; i < 2; i++) begin : g_lvl3
    assign lvl3[i] = {1'b0, lvl2[2*i]} + {1'b0, lvl2[2*i+1]};
  end

  assign count = {1'b0, lvl3[0]} + {1'b0, lvl3[1]};

endmodule

// File: rtl/bnn_lif_accum.sv
// rtl/bnn_lif_accum.sv - leaky integrate-and-fire neuron fed by XNOR words
//
// Purpose : accumulates bipolar popcount contributions of XNOR words into a
//           saturating signed membrane potential; at each timestep end fires
//           (reset to zero) or leaks, and emits one spike result per timestep.
// Ports   : clk, rst (async, active-high), clear (sync, highest priority)
//           in_valid/in_ready/xnor_word/in_last   input word stream
//           threshold                             signed firing threshold (used in EVAL)
//           spike_valid/spike_ready/spike         per-timestep spike result
//           potential                             registered signed membrane value
module bnn_lif_accum
  import bnn_lif_accum_pkg::*;
#(
  parameter int IN_W       = BNN_IN_W,
  parameter int POT_W      = 16,
  parameter int LEAK_SHIFT = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN_W-1:0]         xnor_word,
  input  logic                    in_last,
  input  logic signed [POT_W-1:0] threshold,
  output logic                    spike_valid,
  input  logic                    spike_ready,
  output logic                    spike,
  output logic signed [POT_W-1:0] potential
);

  localparam logic signed [POT_W-1:0] POT_MAX = {1'b0, {(POT_W-1){1'b1}}};
  localparam logic signed [POT_W-1:0] POT_MIN = {1'b1, {(POT_W-1){1'b0}}};

  lif_state_e state_q, state_d;
  logic signed [POT_W-1:0] pot_q, pot_d;
  logic                    spike_q, spike_d;
  logic                    spike_valid_q, spike_valid_d;

  logic [5:0]              pop;
  logic [6:0]              contrib;
  logic signed [POT_W:0]   sum_w;
  logic signed [POT_W-1:0] sat_w;
  logic signed [POT_W-1:0] leak_w;
  logic                    fire;
  logic                    accept;

  popcount_32bits u_popcount (
    .din   (xnor_word[31:0]),
    .count (pop)
  );

  // 7-bit two's complement: 2*pop - 32 wraps correctly even for pop=32.
  assign contrib = {pop, 1'b0} - 7'(CONTRIB_OFFSET);

  // One guard bit is enough: |contrib| <= 32 is far below the potential range.
  assign sum_w = {pot_q[POT_W-1], pot_q} + {{(POT_W-6){contrib[6]}}, contrib};

  always_comb begin
    sat_w = sum_w[POT_W-1:0];
    if (sum_w[POT_W] != sum_w[POT_W-1]) begin
      sat_w = sum_w[POT_W] ? POT_MIN : POT_MAX;
    end
  end

  // Arithmetic shift floors toward -inf, so the subtraction always moves the
  // value toward zero and cannot overflow.
  assign leak_w = pot_q - (pot_q >>> LEAK_SHIFT);
  assign fire   = (pot_q >= threshold);
  assign accept = in_valid & in_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_ACCUM;
      pot_q         <= '0;
      spike_q       <= 1'b0;
      spike_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pot_q         <= pot_d;
      spike_q       <= spike_d;
      spike_valid_q <= spike_valid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_ACCUM;
    end else begin
      unique case (state_q)
        ST_ACCUM: if (accept && in_last) state_d = ST_EVAL;
        ST_EVAL:  state_d = ST_OUT;
        ST_OUT:   if (spike_ready) state_d = ST_ACCUM;
        default:  state_d = ST_ACCUM;
      endcase
    end
  end

  // Datapath next values
  always_comb begin
    pot_d         = pot_q;
    spike_d       = spike_q;
    spike_valid_d = spike_valid_q;
    if (clear) begin
      pot_d         = '0;
      spike_d       = 1'b0;
      spike_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_ACCUM: if (accept) pot_d = sat_w;
        ST_EVAL: begin
          spike_valid_d = 1'b1;
          spike_d       = fire;
          pot_d         = fire ? '0 : leak_w;
        end
        ST_OUT:   if (spike_ready) spike_valid_d = 1'b0;
        default: begin
          pot_d         = '0;
          spike_d       = 1'b0;
          spike_valid_d = 1'b0;
        end
      endcase
    end
  end

  // Outputs
  always_comb begin
    in_ready = (state_q == ST_ACCUM);
  end

  assign spike_valid = spike_valid_q;
  assign spike       = spike_q;
  assign potential   = pot_q;

endmodule

// File: doc/bnn_lif_accum.md
Name: bnn_lif_accum

Overview:
- Sequential neuron stage directly downstream of the 32-bit XNOR gate array, which produces input-spike XNOR weight-bit words.
- Each accepted word is popcounted and converted to a bipolar contribution (2*pop - 32). Contributions are accumulated into a saturating signed membrane potential.
- At each timestep end the block compares against a threshold, then either fires (reset-to-zero) or leaks.
- Emits one spike result per timestep over a valid/ready handshake to the spike router.

Parameters:
- IN_W, 32, word width from the XNOR array. The block is only specified for 32.
- POT_W, 16, signed membrane potential width. Legal range 8..24.
- LEAK_SHIFT, 3, leak amount = membrane >>> LEAK_SHIFT (arithmetic shift).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous clear. Priority over all other activity except rst.
- in_valid  in  1  xnor_word and in_last are valid.
- in_ready  out  1  block accepts a word this cycle.
- xnor_word  in  IN_W  XNOR result word.
- in_last  in  1  final word of the current timestep.
- threshold  in  POT_W  signed firing threshold, sampled in EVAL.
- spike_valid  out  1  spike result available.
- spike_ready  in  1  consumer accepts the result.
- spike  out  1  1 = neuron fired this timestep.
- potential  out  POT_W  signed membrane value, registered.

Behaviour:
- Reset (rst=1, async): state=ACCUM, potential=0, spike=0, spike_valid=0. in_ready=1 once rst deasserts.
- States: ACCUM, EVAL, OUT.
- ACCUM:
  - in_ready=1.
  - Beat accepted when in_valid&in_ready.
  - At the accepting edge: potential <= sat(potential + 2*popcount(xnor_word) - 32).
  - If in_last, go to EVAL; otherwise stay in ACCUM.
- EVAL: in_ready=0, one cycle only, always moves to OUT.
  - If potential >= threshold (signed): spike<=1, potential<=0.
  - Else: spike<=0, potential<=potential - (potential >>> LEAK_SHIFT).
  - spike_valid<=1.
- OUT:
  - in_ready=0. spike_valid, spike and potential are held stable.
  - On spike_valid&spike_ready: spike_valid<=0, go to ACCUM.
- Latency: last beat accepted at edge k -> spike_valid high after edge k+1. Throughput is limited to one timestep result per (beats+2) cycles.
- Arithmetic:
  - Contribution is a signed 7-bit value, range -32..+32.
  - Sum is computed at POT_W+1 bits, then clamped to [-2^(POT_W-1), 2^(POT_W-1)-1].
  - Leak never overflows.
  - Leak of a negative value moves toward 0 and truncates toward -inf (e.g. -3 >>> 3 = -1, so -3 -> -2).
- in_valid while in_ready=0: ignored. Sources must hold the word.
- clear=1, any state: next state=ACCUM, potential=0, spike_valid=0, spike=0. An in_valid beat in the same cycle is dropped, even though in_ready=1 in ACCUM.
- threshold is only observed in EVAL; changes at other times have no effect.
- rst mid-OUT: spike_valid drops immediately (async) and the pending result is lost.

Decomposition:
- Shared Verilog include holds the BNN_IN_W (32) and contribution-offset (32) constants, plus state encodings ACCUM=2'd0, EVAL=2'd1, OUT=2'd2.
- One combinational sub-module, popcount_32bits: 32-bit in, 6-bit count out, built as an adder tree of 4-bit slices. It is reusable by other neuron variants.
- Saturation and leak stay inline.

Test Plan:
- Fire on a single beat: xnor_word=32'hFFFFFFFF, in_last=1, threshold=20 -> spike_valid after 2 edges, spike=1, potential=0.
- Neutral word: 32'h0000FFFF, in_last=1, threshold=1 -> spike=0, potential=0.
- Multi-beat accumulate and leak, threshold=100:
  - Three beats of all-ones (last on the third) -> potential 96, then leak to 84, spike=0.
  - Next timestep, one beat 32'h000000FF (contribution -16) -> 68, then leak to 60, spike=0.
- Saturation with POT_W=8:
  - Four all-ones beats give 128, clamped to 127; threshold=127 -> spike=1.
  - Then five all-zero beats give -160, clamped to -128; after leak potential = -112, spike=0.
- Backpressure: hold spike_ready=0 for 3 cycles in OUT while driving in_valid=1 words.
  - spike_valid and spike stay stable and in_ready=0.
  - No word is consumed and potential is unchanged.
  - A handshake on the 4th cycle returns to ACCUM.
- Clear and reset:
  - clear=1 after two all-ones beats (potential 64), with a simultaneous valid beat -> potential=0 and the beat is dropped.
  - rst asserted mid-OUT -> spike_valid=0 immediately, potential=0.
